mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 data steering path (Mux4) among four requesters.
- Generates the registered 2-bit select and one-hot grant, and enforces a bounded hold time so that no requester can starve the others.
- Sits between the four source units and the shared consumer (bus/write port); the consumer sees out_data qualified by out_valid.

Parameters:
- WIDTH, 32, data width of each input and of out_data.
- MAX_HOLD, 8, maximum consecutive grant cycles per owner while another requester is waiting; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request per source; held high for as long as the source wants the path.
- in0  input  WIDTH  data of source 0.
- in1  input  WIDTH  data of source 1.
- in2  input  WIDTH  data of source 2.
- in3  input  WIDTH  data of source 3.
- gnt  output  4  registered one-hot grant; all zero when idle.
- sel  output  2  registered index of the current or last owner; drives the Mux4 select.
- out_data  output  WIDTH  in[sel], combinational through Mux4.
- out_valid  output  1  registered; high exactly when gnt != 0.

Behaviour:
- Reset values (sampled on clk when reset=1): state=IDLE, gnt=0, sel=0, out_valid=0, last=3 (so source 0 has top priority first), hold_cnt=0. reset overrides every other input. A reset mid-grant drops the grant on that edge.
- States: IDLE and GRANT.
- Round-robin pick: scan the indices last+1, last+2, last+3, last+4 (mod 4) and take the first with req=1.
- IDLE:
  - If req != 0 at an edge, go to GRANT. gnt becomes one-hot(pick), sel=pick, last=pick, hold_cnt=0, out_valid=1.
  - Latency: req sampled at edge N gives gnt visible after edge N, i.e. 1 cycle.
- GRANT, owner o, others = req with bit o masked:
  - req[o]=0 and others=0: go to IDLE. gnt=0, out_valid=0. sel and last keep o.
  - req[o]=0 and others!=0: hand over on the same edge with no idle bubble. New owner = pick over req, last=new owner, hold_cnt=0.
  - req[o]=1 and hold_cnt==MAX_HOLD-1 and others!=0: forced rotation to pick over others, starting after o. hold_cnt=0.
  - Otherwise: keep o. hold_cnt increments, saturating at MAX_HOLD-1.
  - An uncontested owner keeps the grant indefinitely.
- With MAX_HOLD=1, contended owners rotate every cycle.
- The grant is one-hot or zero at all times. sel always equals the index of the set gnt bit while out_valid=1.
- Requests that drop before they are granted are simply not granted. No request latching.
- out_data follows its inputs combinationally, including while idle (it shows in[sel]). Consumers must qualify it with out_valid.
- hold_cnt is 8 bits wide.

Decomposition:
- Shared constants file arb_defs: state encodings (ARB_IDLE=1'b0, ARB_GRANT=1'b1) and the width of hold_cnt.
- Sub-module: the existing Mux4 (WIDTH passed through) for out_data.
- Round-robin pick as a local function or combinational block; no separate module.

Test Plan:
- Reset, then req=4'b0000 for 3 cycles -> gnt=0, sel=0, out_valid=0 throughout.
- After reset, req=4'b0100 at edge N -> gnt=4'b0100, sel=2, out_valid=1 after edge N. Drop req at edge N+3 -> gnt=0 after N+3, sel stays 2.
- After reset, req=4'b1111 held, MAX_HOLD=8 -> grants 0,1,2,3,0 in sequence, each exactly 8 cycles. out_data equals the owner's input value (in0=32'h11111111, in1=32'h22222222, and so on).
- Owner 1 with req=4'b0010, then raise req=4'b1001 while owner 1 drops on the same edge -> next gnt=4'b1000 (index 3 follows 1), no idle cycle.
- Sole requester 0 held for 20 cycles -> gnt stays 4'b0001 and hold_cnt saturates at 7. Raise req[2] -> gnt moves to 4'b0100 on the next edge.
- reset asserted while gnt=4'b0010 -> gnt=0, sel=0, out_valid=0 next edge. After reset releases with req=4'b0011 -> gnt=4'b0001.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared arbiter definitions: state encodings, hold counter width, pick helpers.
// Latency: none (constants and pure functions only).
// Backpressure: n/a.
package mux4_rr_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int HOLD_W = 8;

    function automatic logic [3:0] idx2oh(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // First set request strictly after 'after', wrapping; 'after' itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] after);
        logic [1:0] res;
        logic       found;
        logic [1:0] idx;
        res   = after;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = after + 2'(k);
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4.sv
// 4:1 data steering mux driven by the arbiter select.
// Latency: combinational.
// Backpressure: none; consumers qualify the output with the arbiter valid.
module mux4_rr_arbiter_mux4 #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in0;
        case (sel)
            2'd0: out = in0;
            2'd1: out = in1;
            2'd2: out = in2;
            2'd3: out = in3;
            default: out = in0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one data path, with bounded hold time.
// Latency: request to grant 1 cycle; out_data follows in[sel] combinationally.
// Backpressure: none; a requester holds req until granted, owners rotate after MAX_HOLD contended cycles.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state_q, state_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              valid_q, valid_d;

    logic [3:0] others;
    logic       take;
    logic [1:0] take_idx;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        last_d   = last_q;
        hold_d   = hold_q;
        valid_d  = valid_q;
        take     = 1'b0;
        take_idx = 2'd0;
        // In GRANT the registered grant is exactly the owner's bit.
        others   = req & ~gnt_q;

        case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    take     = 1'b1;
                    take_idx = rr_pick(req, last_q);
                end
            end
            ARB_GRANT: begin
                if (!req[sel_q]) begin
                    if (others == 4'b0000) begin
                        state_d = ARB_IDLE;
                        gnt_d   = 4'b0000;
                        valid_d = 1'b0;
                    end else begin
                        take     = 1'b1;
                        take_idx = rr_pick(req, last_q);
                    end
                end else if (hold_q == HOLD_LAST && others != 4'b0000) begin
                    take     = 1'b1;
                    take_idx = rr_pick(others, sel_q);
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (take) begin
            state_d = ARB_GRANT;
            gnt_d   = idx2oh(take_idx);
            sel_d   = take_idx;
            last_d  = take_idx;
            hold_d  = '0;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_valid = valid_q;

    mux4_rr_arbiter_mux4 #(
        .WIDTH(WIDTH)
    ) u_mux4 (
        .sel(sel_q),
        .in0(in0),
        .in1(in1),
        .in2(in2),
        .in3(in3),
        .out(out_data)
    );

endmodule
